// File: rtl/uart_rx_buffer.sv
// Receive-side buffer between a UART and the memory arbiter: captures each
// received byte into a FIFO and drains it to memory as a data/flag write pair.
module uart_rx_buffer #(
  parameter int                DEPTH     = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] DATA_ADDR = 12'h800,
  parameter logic [ADDR_W-1:0] FLAG_ADDR = 12'h801,
  parameter logic [7:0]        FLAG_BYTE = 8'h0C
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rxReady,
  input  logic [7:0]                   rxDataIn,
  output logic                         rxClear,
  input  logic                         memGrant,
  output logic                         memReq,
  output logic                         memWriteOut,
  output logic [ADDR_W-1:0]            memAddress,
  output logic [7:0]                   memWriteData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         overflowClear
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_CLEAR = 2'd1,
    C_WAIT  = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_DATA = 2'd1,
    D_FLAG = 2'd2
  } drn_state_t;

  cap_state_t        r_cap_state;
  drn_state_t        r_drn_state;
  logic [7:0]        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic              w_pop;
  logic              w_full;
  logic              w_rx_take;
  logic              w_push;
  logic              w_drop;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign w_pop     = (r_drn_state == D_DATA) && memGrant;
  assign w_full    = (r_count == CW'(DEPTH)) && !w_pop;
  assign w_rx_take = (r_cap_state == C_IDLE) && rxReady;
  assign w_push    = w_rx_take && !w_full;
  assign w_drop    = w_rx_take && w_full;

  // Capture FSM: take one byte, pulse the UART clear, wait for the flag to fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_state <= C_IDLE;
    end else begin
      case (r_cap_state)
        C_IDLE: begin
          if (rxReady) begin
            r_cap_state <= C_CLEAR;
          end else begin
            r_cap_state <= C_IDLE;
          end
        end
        C_CLEAR: begin
          r_cap_state <= C_WAIT;
        end
        C_WAIT: begin
          if (!rxReady) begin
            r_cap_state <= C_IDLE;
          end else begin
            r_cap_state <= C_WAIT;
          end
        end
        default: begin
          r_cap_state <= C_IDLE;
        end
      endcase
    end
  end

  // Drain FSM: each byte becomes a data write followed by a marker write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drn_state <= D_IDLE;
    end else begin
      case (r_drn_state)
        D_IDLE: begin
          if (r_count != {CW{1'b0}}) begin
            r_drn_state <= D_DATA;
          end else begin
            r_drn_state <= D_IDLE;
          end
        end
        D_DATA: begin
          if (memGrant) begin
            r_drn_state <= D_FLAG;
          end else begin
            r_drn_state <= D_DATA;
          end
        end
        D_FLAG: begin
          if (memGrant) begin
            r_drn_state <= D_IDLE;
          end else begin
            r_drn_state <= D_FLAG;
          end
        end
        default: begin
          r_drn_state <= D_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rxDataIn;
    end
  end

  // Sticky overflow; a drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflowClear) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Write-port decode; address and data are forced to 0 when no write is issued.
  always_comb begin
    w_write = 1'b0;
    w_addr  = {ADDR_W{1'b0}};
    w_wdata = 8'h00;
    if (memGrant && (r_drn_state == D_DATA)) begin
      w_write = 1'b1;
      w_addr  = DATA_ADDR;
      w_wdata = r_mem[r_rd_ptr];
    end else if (memGrant && (r_drn_state == D_FLAG)) begin
      w_write = 1'b1;
      w_addr  = FLAG_ADDR;
      w_wdata = FLAG_BYTE;
    end else begin
      w_write = 1'b0;
      w_addr  = {ADDR_W{1'b0}};
      w_wdata = 8'h00;
    end
  end

  assign rxClear      = (r_cap_state == C_CLEAR);
  assign memReq       = (r_drn_state != D_IDLE);
  assign memWriteOut  = w_write;
  assign memAddress   = w_addr;
  assign memWriteData = w_wdata;
  assign count        = r_count;
  assign overflow     = r_overflow;

endmodule
